// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered word, one digit
// per PRESCALE slot, optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    load_i,
  input  logic                    blank_zeros_i,
  output logic [3:0]              cuenta_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] SEL_RST =
    SEL_OFF ^ NUM_DIGITS'(1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic [3:0]            cuenta_q, cuenta_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_q, frame_d;

  logic       tick, boundary, upper_zero, blank;
  logic [3:0] nib;

  always_comb begin
    tick       = (presc_q == P_LAST);
    boundary   = tick && (idx_q == I_LAST);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = load_i ? data_i : pend_q;
    pending_d  = pending_q;
    cuenta_d   = cuenta_q;
    sel_d      = sel_q;
    frame_d    = boundary;
    upper_zero = 1'b1;
    blank      = 1'b0;
    nib        = 4'h0;

    if (tick)
      idx_d = boundary ? '0 : idx_q + IW'(1);

    if (boundary) begin
      pending_d = 1'b0;
      if (load_i)
        disp_d = data_i;
      else if (pending_q)
        disp_d = pend_q;
    end else if (load_i) begin
      pending_d = 1'b1;
    end

    // Scan from the top digit down, tracking "all higher nibbles zero"
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_d[4*k +: 4] == 4'h0);
      if (idx_d == IW'(k)) begin
        nib   = disp_d[4*k +: 4];
        blank = blank_zeros_i && upper_zero && (k != 0);
      end
    end

    if (tick) begin
      cuenta_d = blank ? 4'h0 : nib;
      sel_d    = blank ? SEL_OFF
                       : SEL_OFF ^ (NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      cuenta_q  <= 4'h0;
      sel_q     <= SEL_RST;
      frame_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      cuenta_q  <= cuenta_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  assign cuenta_o    = cuenta_q;
  assign digit_sel_o = sel_q;
  assign frame_o     = frame_q;
  assign pending_o   = pending_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Multiplexed-display scan controller that sits directly upstream of the 7-segment nibble decoder. It holds a NUM_DIGITS-nibble word, typically a RAM read word, and time-multiplexes it one digit at a time. It drives a 4-bit hex value into the decoder's count input and a one-hot digit-select to the display commons. New data is double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned; data width is 4*NUM_DIGITS.
PRESCALE, 50000, clk_i cycles per digit slot; must be >= 1.
SEL_ACTIVE_LOW, 1, 1 = digit_sel_o active-low (common-anode board), 0 = active-high.

Ports:
clk_i  in  1  system clock, single domain.
rst_i  in  1  reset; asynchronous, active-high.
data_i  in  4*NUM_DIGITS  word to display; nibble k drives digit k; digit 0 is least significant.
load_i  in  1  single-cycle strobe; captures data_i into the pending buffer.
blank_zeros_i  in  1  1 = suppress leading-zero digits.
cuenta_o  out  4  hex nibble of the active digit; goes to the decoder count input.
digit_sel_o  out  NUM_DIGITS  one-hot digit enable, polarity set by SEL_ACTIVE_LOW.
frame_o  out  1  one-cycle pulse when a new frame starts (digit 0 selected).
pending_o  out  1  1 = loaded word not yet applied to the display.

Behaviour:
- Reset (async, rst_i=1) sets:
  - prescaler=0, idx=0;
  - display_reg=0, pending_reg=0, pending_o=0;
  - cuenta_o=0, frame_o=0;
  - digit_sel_o = digit 0 active (4'b1110 for defaults).
  On release, scanning resumes from digit 0 showing 0.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 in the cycle where prescaler==PRESCALE-1. If PRESCALE=1, tick is asserted every cycle.
- Digit index idx: advances on each tick, NUM_DIGITS-1 -> 0 wrap. The wrap tick is the frame boundary.
- Outputs: all registered, no combinational input-to-output path.
  - cuenta_o, digit_sel_o and frame_o are computed from next-state values, so they change on the same edge as idx and display_reg.
  - Each digit is held for exactly PRESCALE cycles.
- cuenta_o = display_reg[4*idx +: 4] for the new idx.
- frame_o = 1 for exactly one cycle, following the edge where idx wraps to 0. Period is NUM_DIGITS*PRESCALE cycles.
- Load without a boundary: load_i=1 sets pending_reg<=data_i and pending_o<=1. Repeated loads within a frame overwrite; the last one wins.
- Boundary with pending_o=1 and no load: display_reg<=pending_reg, pending_o<=0.
- load_i on the boundary cycle: data_i bypasses to display_reg, pending_reg<=data_i, pending_o<=0. The new digit 0 shows data_i's nibble 0 on that edge.
- display_reg never changes mid-frame.
- Leading-zero blanking, with blank_zeros_i=1:
  - Digit k>0 is blanked if nibbles k..NUM_DIGITS-1 of display_reg are all zero.
  - A blanked digit has digit_sel_o all inactive and cuenta_o=0.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - blank_zeros_i is sampled on the output-update edge.
- load_i during reset is ignored.

Test Plan:
- Reset: PRESCALE=4, rst_i pulsed -> cuenta_o=0, digit_sel_o=4'b1110, frame_o=0, pending_o=0; after release idx advances every 4 cycles and frame_o pulses every 16 cycles.
- Mid-frame load: load 16'h1234 at idx=1 -> pending_o=1; outputs keep showing 0 until the boundary; then cuenta_o 4,3,2,1 with sel 1110,1101,1011,0111, 4 cycles each; pending_o=0.
- Blanking:
  - 16'h0005, blank_zeros_i=1 -> digit 0 shows 5 with sel 1110; digits 1-3 give sel 1111, cuenta_o 0.
  - 16'h0000 -> digit 0 shows 0.
  - 16'h0500 -> digits 0,1,2 shown, digit 3 blanked.
- Boundary collision: pending holds 16'h1111; load 16'hABCD on the wrap tick -> digit 0 shows D, then C,B,A; pending_o=0; 1 never displayed.
- Multiple loads: 16'h1111 then 16'h2222 in the same frame -> next frame shows 2,2,2,2.
- Reset mid-operation: assert rst_i between edges while displaying 16'h1234 at idx=2 -> outputs return to reset values immediately, without waiting for a clock edge; after release, 0 is shown and pending_o=0.
